// File: rtl/vector_mul_simple.sv
// Combinational signed DATA_W x DATA_W multiplier: radix-4 Booth partial products,
// a 3:2 carry-save reduction tree and one final carry-propagate adder.
module vector_mul_simple #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  input  logic [DATA_W-1:0]     in_a_i,
  input  logic [DATA_W-1:0]     in_b_i,
  output logic                  out_valid_o,
  output logic [2*DATA_W-1:0]   out_result_o
);

  localparam int unsigned PW     = 2 * DATA_W;
  localparam int unsigned NPP    = DATA_W / 2 + 1;
  localparam int unsigned LEVELS = 8;

  logic [PW-1:0]     a_ext;
  logic [DATA_W+2:0] b_ext;
  logic [PW-1:0]     pp [NPP];
  logic [PW-1:0]     sum_row;
  logic [PW-1:0]     carry_row;
  logic [PW-1:0]     product;

  assign a_ext = {{DATA_W{in_a_i[DATA_W-1]}}, in_a_i};
  // Implicit zero below bit 0 and two sign bits above so every Booth group is in range.
  assign b_ext = {in_b_i[DATA_W-1], in_b_i[DATA_W-1], in_b_i, 1'b0};

  always_comb begin
    logic [PW-1:0] mult;
    for (int unsigned i = 0; i < NPP; i++) begin
      mult = '0;
      case (b_ext[2*i +: 3])
        3'b001, 3'b010: mult = a_ext;
        3'b011:         mult = a_ext << 1;
        3'b100:         mult = -(a_ext << 1);
        3'b101, 3'b110: mult = -a_ext;
        default:        mult = '0;
      endcase
      pp[i] = mult << (2 * i);
    end
  end

  // Wallace-style levels: each level compresses complete triples, passes leftovers through.
  always_comb begin
    logic [PW-1:0] rows [NPP];
    logic [PW-1:0] nxt  [NPP];
    int unsigned   cnt;
    int unsigned   ncnt;
    rows = pp;
    nxt  = pp;
    cnt  = NPP;
    ncnt = 0;
    for (int unsigned lvl = 0; lvl < LEVELS; lvl++) begin
      if (cnt > 2) begin
        for (int unsigned k = 0; k < NPP; k++) nxt[k] = '0;
        ncnt = 0;
        for (int unsigned g = 0; g < NPP / 3; g++) begin
          if (3 * g + 2 < cnt) begin
            nxt[ncnt]     = rows[3*g] ^ rows[3*g+1] ^ rows[3*g+2];
            nxt[ncnt + 1] = ((rows[3*g] & rows[3*g+1]) |
                             (rows[3*g] & rows[3*g+2]) |
                             (rows[3*g+1] & rows[3*g+2])) << 1;
            ncnt = ncnt + 2;
          end
        end
        for (int unsigned k = 0; k < NPP; k++) begin
          if (k >= (cnt / 3) * 3 && k < cnt) begin
            nxt[ncnt] = rows[k];
            ncnt = ncnt + 1;
          end
        end
        rows = nxt;
        cnt  = ncnt;
      end
    end
    sum_row   = rows[0];
    carry_row = rows[1];
  end

  assign product = sum_row + carry_row;

  always_comb begin
    out_valid_o  = in_valid_i & ~rst_i;
    out_result_o = out_valid_o ? product : '0;
  end

  assert property (@(posedge clk_i) !(rst_i && out_valid_o));

endmodule

// File: tb/tb_vector_mul_simple.sv
// Bench for vector_mul_simple: directed vector table, reset sequence and
// randomized stream checked against a wide-multiply reference.
module tb_vector_mul_simple;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic [63:0] out_result;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  vector_mul_simple #(.DATA_W(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_a_i       (in_a),
    .in_b_i       (in_b),
    .out_valid_o  (out_valid),
    .out_result_o (out_result)
  );

  typedef struct {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp_valid;
    logic [63:0] exp_result;
  } vec_t;

  vec_t tbl [15];

  function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  task automatic check(input string name, input logic exp_v, input logic [63:0] exp_r);
    tests++;
    if (out_valid !== exp_v || out_result !== exp_r) begin
      fails++;
      $display("FAIL %s: got valid=%0b result=%h, expected valid=%0b result=%h",
               name, out_valid, out_result, exp_v, exp_r);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    rst = r; in_valid = v; in_a = a; in_b = b;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;

    tbl[0]  = '{1'b1, 32'd0,          32'd0,          1'b1, 64'd0};
    tbl[1]  = '{1'b1, 32'd1,          32'd0,          1'b1, 64'd0};
    tbl[2]  = '{1'b1, 32'd0,          32'd1,          1'b1, 64'd0};
    tbl[3]  = '{1'b1, 32'd1,          32'd1,          1'b1, 64'd1};
    tbl[4]  = '{1'b1, 32'hFFFFFFFF,   32'd1,          1'b1, 64'hFFFFFFFF_FFFFFFFF};
    tbl[5]  = '{1'b1, 32'd1,          32'hFFFFFFFF,   1'b1, 64'hFFFFFFFF_FFFFFFFF};
    tbl[6]  = '{1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 64'd1};
    tbl[7]  = '{1'b1, 32'h7FFFFFFF,   32'd2,          1'b1, 64'h00000000_FFFFFFFE};
    tbl[8]  = '{1'b1, 32'h80000000,   32'd2,          1'b1, 64'hFFFFFFFF_00000000};
    tbl[9]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   1'b1, 64'h00000000_80000000};
    tbl[10] = '{1'b1, 32'h7FFFFFFF,   32'h7FFFFFFF,   1'b1, 64'h3FFFFFFF_00000001};
    tbl[11] = '{1'b1, 32'h80000000,   32'h80000000,   1'b1, 64'h40000000_00000000};
    tbl[12] = '{1'b0, 32'd123,        32'd456,        1'b0, 64'd0};
    tbl[13] = '{1'b1, 32'd1000,       32'hFFFFFFFD,   1'b1, 64'hFFFFFFFF_FFFFF448};
    tbl[14] = '{1'b1, 32'h00010000,   32'h00010000,   1'b1, 64'h00000001_00000000};

    // Reset state with valid operands present
    drive(1'b1, 1'b1, 32'd5, 32'd7);
    check("reset_hold", 1'b0, 64'd0);
    drive(1'b0, 1'b1, 32'd5, 32'd7);
    check("reset_release", 1'b1, 64'd35);

    for (int i = 0; i < 15; i++) begin
      drive(1'b0, tbl[i].valid, tbl[i].a, tbl[i].b);
      check($sformatf("vec%0d", i), tbl[i].exp_valid, tbl[i].exp_result);
    end

    // Bubble between back-to-back valid cycles
    drive(1'b0, 1'b1, 32'd3, 32'd4);
    check("b2b_first", 1'b1, 64'd12);
    drive(1'b0, 1'b0, 32'hDEADBEEF, 32'h12345678);
    check("bubble", 1'b0, 64'd0);
    drive(1'b0, 1'b1, 32'hFFFFFFF9, 32'd6);
    check("b2b_after_bubble", 1'b1, 64'hFFFFFFFF_FFFFFFD6);

    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic        r;
      logic        v;
      logic [31:0] a;
      logic [31:0] b;
      logic        ev;
      r = (cyc >= 1000 && cyc < 1003);
      v = ($urandom_range(0, 9) < 7);
      a = $urandom;
      b = $urandom;
      if (cyc % 97 == 0) a = 32'h80000000;
      drive(r, v, a, b);
      ev = v && !r;
      check($sformatf("rand%0d", cyc), ev, ev ? ref_product(a, b) : 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
